// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package mem_pkg;

  localparam int MEM_DW = 32;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_ACC  = 1'b1;

  typedef struct packed {
    logic              write;
    logic [MEM_DW-1:0] addr;
    logic [MEM_DW-1:0] wdata;
  } mem_req_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_burst_picker.sv
// Round-robin owner choice with bounded burst hold-over; owns the burst counter.
module rr_burst_picker
  import mem_pkg::*;
#(
  parameter int MaxBurst = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic core_req_i,
  input  logic acc_req_i,
  input  logic last_owner_i,
  input  logic done_i,
  input  logic done_owner_i,
  output logic pick_o
);

  localparam int CntW = $clog2(MaxBurst + 1);
  localparam logic [CntW-1:0] MAX_CNT = CntW'(MaxBurst);

  logic [CntW-1:0] burst_cnt_q;
  logic            hold;

  // A zero count means no live streak (only after reset), so the tie goes away from last_owner.
  assign hold = (burst_cnt_q != '0) && (burst_cnt_q < MAX_CNT);

  always_comb begin
    pick_o = REQ_CORE;
    if (core_req_i && acc_req_i) begin
      pick_o = hold ? last_owner_i : ~last_owner_i;
    end else if (acc_req_i) begin
      pick_o = REQ_ACC;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      burst_cnt_q <= '0;
    end else if (done_i) begin
      if (done_owner_i == last_owner_i) begin
        burst_cnt_q <= (burst_cnt_q == MAX_CNT) ? burst_cnt_q : burst_cnt_q + CntW'(1);
      end else begin
        burst_cnt_q <= CntW'(1);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: IDLE/BUSY FSM, request latches and response demux.
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int DWidth   = MEM_DW,
  parameter int MaxBurst = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              core_req_i,
  input  logic              core_write_i,
  input  logic [DWidth-1:0] core_addr_i,
  input  logic [DWidth-1:0] core_wdata_i,
  output logic              core_ready_o,
  output logic [DWidth-1:0] core_rdata_o,
  input  logic              acc_req_i,
  input  logic              acc_write_i,
  input  logic [DWidth-1:0] acc_addr_i,
  input  logic [DWidth-1:0] acc_wdata_i,
  output logic              acc_ready_o,
  output logic [DWidth-1:0] acc_rdata_o,
  output logic              mem_req_o,
  output logic              mem_write_o,
  output logic [DWidth-1:0] mem_addr_o,
  output logic [DWidth-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [DWidth-1:0] mem_rdata_i,
  output logic [1:0]        grant_o,
  output arb_state_e        state_o
);

  // Handshake on every side: req and its attributes stay stable until a one-cycle
  // ready pulse completes the transaction; there is no abort path.

  typedef struct packed {
    logic              write;
    logic [DWidth-1:0] addr;
    logic [DWidth-1:0] wdata;
  } lat_t;

  arb_state_e state_q, state_d;
  logic       owner_q;
  logic       last_owner_q;
  lat_t       lat_q;
  logic       pick;
  logic       start;
  logic       done;

  assign start = (state_q == ST_IDLE) && (core_req_i || acc_req_i);
  assign done  = (state_q == ST_BUSY) && mem_ready_i;

  rr_burst_picker #(
    .MaxBurst(MaxBurst)
  ) u_picker (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .core_req_i  (core_req_i),
    .acc_req_i   (acc_req_i),
    .last_owner_i(last_owner_q),
    .done_i      (done),
    .done_owner_i(owner_q),
    .pick_o      (pick)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (core_req_i || acc_req_i) state_d = ST_BUSY;
      ST_BUSY: if (mem_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      owner_q      <= REQ_CORE;
      last_owner_q <= REQ_ACC;
      lat_q        <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        owner_q <= pick;
        lat_q   <= (pick == REQ_ACC) ? lat_t'{acc_write_i, acc_addr_i, acc_wdata_i}
                                     : lat_t'{core_write_i, core_addr_i, core_wdata_i};
      end
      if (done) last_owner_q <= owner_q;
    end
  end

  assign mem_req_o   = (state_q == ST_BUSY);
  assign mem_write_o = lat_q.write;
  assign mem_addr_o  = lat_q.addr;
  assign mem_wdata_o = lat_q.wdata;
  assign grant_o     = (state_q == ST_BUSY) ? ((owner_q == REQ_ACC) ? 2'b10 : 2'b01) : 2'b00;
  assign state_o     = state_q;

  assign core_ready_o = done && (owner_q == REQ_CORE);
  assign acc_ready_o  = done && (owner_q == REQ_ACC);
  assign core_rdata_o = core_ready_o ? mem_rdata_i : '0;
  assign acc_rdata_o  = acc_ready_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized two-requester traffic vs a reference model.
module tb_dmem_arbiter;
  import mem_pkg::*;

  localparam int DW   = 32;
  localparam int MAXB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          core_req_i = 0, core_write_i = 0, acc_req_i = 0, acc_write_i = 0;
  logic [DW-1:0] core_addr_i = 0, core_wdata_i = 0, acc_addr_i = 0, acc_wdata_i = 0;
  logic          core_ready_o, acc_ready_o, mem_req_o, mem_write_o;
  logic [DW-1:0] core_rdata_o, acc_rdata_o, mem_addr_o, mem_wdata_o;
  logic          mem_ready_i = 0;
  logic [DW-1:0] mem_rdata_i = 0;
  logic [1:0]    grant_o;
  arb_state_e    state_o;

  dmem_arbiter #(.DWidth(DW), .MaxBurst(MAXB)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(core_req_i), .core_write_i(core_write_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_ready_o(core_ready_o), .core_rdata_o(core_rdata_o),
    .acc_req_i(acc_req_i), .acc_write_i(acc_write_i), .acc_addr_i(acc_addr_i),
    .acc_wdata_i(acc_wdata_i), .acc_ready_o(acc_ready_o), .acc_rdata_o(acc_rdata_o),
    .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .grant_o(grant_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // requester and memory state kept by the bench
  mem_req_t rq[2][$];
  mem_req_t att[2];
  bit       req_v[2];
  bit       done_f[2];
  int       gap[2];
  bit       rand_gap = 0;
  int       lat_min = 1, lat_max = 1;
  bit       mem_busy = 0;
  int       mem_cnt = 0;
  bit       stray = 0;
  logic [31:0] mem_model[logic [31:0]];
  logic [31:0] last_rdata[2];
  int       comp_log[$];

  // reference arbitration model: last owner and length of its current streak
  bit       m_last = 1;
  int       m_cnt = 0;
  logic [1:0] prev_grant = 2'b00;

  function automatic bit model_pick(bit c, bit a);
    if (c && !a) return 1'b0;
    if (a && !c) return 1'b1;
    if (m_cnt > 0 && m_cnt < MAXB) return m_last;
    return !m_last;
  endfunction

  task automatic drive_reqs();
    core_req_i = req_v[0]; core_write_i = att[0].write;
    core_addr_i = att[0].addr; core_wdata_i = att[0].wdata;
    acc_req_i = req_v[1]; acc_write_i = att[1].write;
    acc_addr_i = att[1].addr; acc_wdata_i = att[1].wdata;
  endtask

  task automatic clear_bench();
    for (int r = 0; r < 2; r++) begin
      rq[r].delete(); req_v[r] = 0; done_f[r] = 0; gap[r] = 0; att[r] = '0;
    end
    drive_reqs();
    mem_ready_i = 0; mem_rdata_i = 0; mem_busy = 0; stray = 0;
    m_last = 1; m_cnt = 0; prev_grant = 2'b00;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_bench();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic step();
    logic [1:0] g;
    bit own;
    @(negedge clk);
    g = grant_o;
    if (prev_grant == 2'b00) begin
      if (core_req_i || acc_req_i)
        check_eq("grant_pick", 32'(g), model_pick(core_req_i, acc_req_i) ? 32'h2 : 32'h1);
      else
        check_eq("grant_idle", 32'(g), 32'h0);
    end
    if (g != 2'b00) begin
      own = g[1];
      check_eq("mem_req_busy", 32'(mem_req_o), 32'h1);
      if (rq[own].size() > 0) begin
        check_eq("mem_write", 32'(mem_write_o), 32'(rq[own][0].write));
        check_eq("mem_addr", mem_addr_o, rq[own][0].addr);
        check_eq("mem_wdata", mem_wdata_o, rq[own][0].wdata);
      end else begin
        check_eq("owner_has_txn", 32'h0, 32'h1);
      end
    end else begin
      check_eq("mem_req_idle", 32'(mem_req_o), 32'h0);
    end
    // requester drivers
    for (int r = 0; r < 2; r++) begin
      if (done_f[r]) begin
        void'(rq[r].pop_front());
        done_f[r] = 0; req_v[r] = 0;
        gap[r] = rand_gap ? int'($urandom_range(0, 2)) : 0;
      end
      if (!req_v[r]) begin
        if (gap[r] > 0) gap[r]--;
        else if (rq[r].size() > 0) begin req_v[r] = 1; att[r] = rq[r][0]; end
      end
    end
    drive_reqs();
    // memory responder
    if (mem_ready_i) begin
      mem_ready_i = 0; mem_rdata_i = 0;
    end else if (stray) begin
      mem_ready_i = 1; mem_rdata_i = $urandom; stray = 0;
    end else if (mem_req_o) begin
      if (!mem_busy) begin mem_busy = 1; mem_cnt = int'($urandom_range(lat_min, lat_max)); end
      if (mem_cnt == 0) begin
        mem_ready_i = 1; mem_busy = 0;
        if (mem_write_o) begin
          mem_model[mem_addr_o] = mem_wdata_o; mem_rdata_i = $urandom;
        end else begin
          mem_rdata_i = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o] : 32'h0;
        end
      end else mem_cnt--;
    end
    #1;
    if (mem_ready_i && g != 2'b00) begin
      own = g[1];
      check_eq("owner_ready", 32'(own ? acc_ready_o : core_ready_o), 32'h1);
      check_eq("owner_rdata", own ? acc_rdata_o : core_rdata_o, mem_rdata_i);
      check_eq("other_ready", 32'(own ? core_ready_o : acc_ready_o), 32'h0);
      check_eq("other_rdata", own ? core_rdata_o : acc_rdata_o, 32'h0);
      last_rdata[own] = own ? acc_rdata_o : core_rdata_o;
      done_f[own] = 1;
      comp_log.push_back(int'(own));
      if (own == m_last) m_cnt = (m_cnt < MAXB) ? m_cnt + 1 : MAXB;
      else m_cnt = 1;
      m_last = own;
    end else begin
      check_eq("no_ready", 32'({core_ready_o, acc_ready_o}), 32'h0);
    end
    prev_grant = g;
  endtask

  function automatic bit bench_idle();
    return rq[0].size() == 0 && rq[1].size() == 0 && !req_v[0] && !req_v[1]
           && grant_o == 2'b00 && !mem_ready_i;
  endfunction

  task automatic run_until_idle(input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!bench_idle() && n < budget);
    if (!bench_idle()) check_eq("idle_timeout", 32'(n), 32'(budget + 1));
  endtask

  function automatic mem_req_t mk(bit w, logic [31:0] a, logic [31:0] d);
    mem_req_t t;
    t.write = w; t.addr = a; t.wdata = d;
    return t;
  endfunction

  initial begin
    int s, idx, ncore, acc_done;
    clear_bench();
    do_reset();
    #1;
    check_eq("rst_state", 32'(state_o), 32'(ST_IDLE));
    check_eq("rst_grant", 32'(grant_o), 32'h0);
    check_eq("rst_mem_req", 32'(mem_req_o), 32'h0);
    check_eq("rst_mem_addr", mem_addr_o, 32'h0);
    check_eq("rst_ready", 32'({core_ready_o, acc_ready_o}), 32'h0);

    // core-only load
    mem_model[32'h4000] = 32'hDEADBEEF;
    rq[0].push_back(mk(0, 32'h4000, 32'h0));
    step();
    check_eq("t1_req_up", 32'(core_req_i), 32'h1);
    check_eq("t1_mem_req_wait", 32'(mem_req_o), 32'h0);
    step();
    check_eq("t1_mem_req_rise", 32'(mem_req_o), 32'h1);
    check_eq("t1_addr", mem_addr_o, 32'h4000);
    run_until_idle(50);
    check_eq("t1_rdata", last_rdata[0], 32'hDEADBEEF);

    // simultaneous first requests after reset: core first
    do_reset();
    s = comp_log.size();
    rq[0].push_back(mk(0, 32'h4000, 0));
    rq[1].push_back(mk(0, 32'h4004, 0));
    run_until_idle(50);
    check_eq("t2_first", 32'(comp_log[s]), 32'h0);
    check_eq("t2_second", 32'(comp_log[s+1]), 32'h1);

    // accelerator stream with core joining after the 3rd completion
    do_reset();
    s = comp_log.size();
    for (int i = 0; i < 20; i++) rq[1].push_back(mk(0, 32'h8000 + 32'(i * 4), 0));
    acc_done = 0;
    for (int n = 0; n < 200 && acc_done < 3; n++) begin
      step();
      acc_done = comp_log.size() - s;
    end
    rq[0].push_back(mk(0, 32'h4000, 0));
    run_until_idle(200);
    idx = -1; ncore = 0;
    for (int i = s; i < comp_log.size(); i++)
      if (comp_log[i] == 0) begin ncore++; if (idx < 0) idx = i - s; end
    check_eq("t3_core_slot", 32'(idx), 32'd8);
    check_eq("t3_core_once", 32'(ncore), 32'd1);
    check_eq("t3_total", 32'(comp_log.size() - s), 32'd21);

    // store then load back
    rq[0].push_back(mk(1, 32'h4010, 32'h12345678));
    rq[0].push_back(mk(0, 32'h4010, 32'h0));
    run_until_idle(50);
    check_eq("t4_load_back", last_rdata[0], 32'h12345678);

    // reset while BUSY
    rq[1].push_back(mk(0, 32'h4000, 0));
    lat_min = 3; lat_max = 3;
    for (int n = 0; n < 20 && grant_o == 2'b00; n++) step();
    check_eq("t5_busy_before", 32'(grant_o), 32'h2);
    rst_n = 0;
    #1;
    check_eq("t5_rst_mem_req", 32'(mem_req_o), 32'h0);
    check_eq("t5_rst_grant", 32'(grant_o), 32'h0);
    check_eq("t5_rst_mem_bus", {mem_addr_o | mem_wdata_o}, 32'h0);
    check_eq("t5_rst_write", 32'(mem_write_o), 32'h0);
    check_eq("t5_rst_rdata", core_rdata_o | acc_rdata_o, 32'h0);
    check_eq("t5_rst_state", 32'(state_o), 32'(ST_IDLE));
    clear_bench();
    @(negedge clk);
    rst_n = 1;
    lat_min = 1; lat_max = 1;
    s = comp_log.size();
    rq[1].push_back(mk(0, 32'h4000, 0));
    run_until_idle(50);
    check_eq("t5_regrant", 32'(comp_log.size() - s), 32'h1);
    check_eq("t5_regrant_rdata", last_rdata[1], 32'hDEADBEEF);

    // stray memory ready while idle
    stray = 1;
    step();
    step();
    check_eq("t6_state", 32'(state_o), 32'(ST_IDLE));
    check_eq("t6_grant", 32'(grant_o), 32'h0);

    // randomized contention
    rand_gap = 1; lat_min = 1; lat_max = 3;
    s = comp_log.size();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 60; i++)
        rq[r].push_back(mk(1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 15) * 4), $urandom));
    run_until_idle(5000);
    check_eq("rand_count", 32'(comp_log.size() - s), 32'd120);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
